// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Round-robin sequencer sharing one combinational ALU between two
//               valid/ready requesters; result returned with a requester ID tag.
//               Optional ALU_FLAGS_EN adds zero/carry result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
`ifdef ALU_FLAGS_EN
    input  logic              alu_cout,
    output logic              resp_zero,
    output logic              resp_carry,
`endif
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_y,
    output logic              resp_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   resp_y_q, resp_y_d;
    logic                resp_id_q, resp_id_d;
    logic                resp_valid_q, resp_valid_d;
`ifdef ALU_FLAGS_EN
    logic                resp_zero_q, resp_zero_d;
    logic                resp_carry_q, resp_carry_d;
`endif
    logic                grant_id;
    logic                any_valid;

    always_comb begin
        any_valid    = req0_valid | req1_valid;
        grant_id     = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_y_d     = resp_y_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
`ifdef ALU_FLAGS_EN
        resp_zero_d  = resp_zero_q;
        resp_carry_d = resp_carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Ready is masked while reset is held so nothing looks accepted.
                if (any_valid && rst_n) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    alu_op_d   = grant_id ? req1_op : req0_op;
                    alu_a_d    = grant_id ? req1_a  : req0_a;
                    alu_b_d    = grant_id ? req1_b  : req0_b;
                    resp_id_d  = grant_id;
                    rr_ptr_d   = ~grant_id;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_y_d     = alu_y;
                resp_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
                resp_zero_d  = (alu_y == '0);
                resp_carry_d = alu_cout;
`endif
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_y_q     <= '0;
            resp_id_q    <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
            resp_zero_q  <= 1'b0;
            resp_carry_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_y_q     <= resp_y_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
`ifdef ALU_FLAGS_EN
            resp_zero_q  <= resp_zero_d;
            resp_carry_q <= resp_carry_d;
`endif
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign resp_y     = resp_y_q;
    assign resp_id    = resp_id_q;
    assign resp_valid = resp_valid_q;
`ifdef ALU_FLAGS_EN
    assign resp_zero  = resp_zero_q;
    assign resp_carry = resp_carry_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Directed self-checking bench for alu_share_ctrl with a local
//               ALU model (AND/OR/XOR/XNOR/ADD/SUB).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic              req1_valid, req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic              alu_cout;
    logic              resp_valid, resp_ready, resp_id;
    logic [DATA_W-1:0] resp_y;
`ifdef ALU_FLAGS_EN
    logic              resp_zero, resp_carry;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
`ifdef ALU_FLAGS_EN
        .alu_cout   (alu_cout),
        .resp_zero  (resp_zero),
        .resp_carry (resp_carry),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id)
    );

    logic [DATA_W:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_op)
            3'b000:  alu_t = {1'b0, alu_a & alu_b};
            3'b001:  alu_t = {1'b0, alu_a | alu_b};
            3'b010:  alu_t = {1'b0, alu_a ^ alu_b};
            3'b011:  alu_t = {1'b0, ~(alu_a ^ alu_b)};
            3'b100:  alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            3'b101:  alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_t = '0;
        endcase
        alu_y    = alu_t[DATA_W-1:0];
        alu_cout = alu_t[DATA_W];
    end

    typedef struct {
        logic              id;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] y;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Single operation from IDLE with resp_ready high; returns back in IDLE.
    task automatic run_single(input vec_t v);
        resp_ready = 1'b1;
        drive(v.id, v.op, v.a, v.b);
        #1;
        check("grant_ready", {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("exec_ready", {req1_ready, req0_ready}, 2'b00);
        check("exec_valid", resp_valid, 1'b0);
        check("alu_regs", {alu_op, alu_a, alu_b}, {v.op, v.a, v.b});
        tick();
        check("resp_valid", resp_valid, 1'b1);
        check("resp_y", resp_y, v.y);
        check("resp_id", resp_id, v.id);
        tick();
        check("resp_done", resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 3'b011, 4'b1010, 4'b1100, 4'b1001};
        vecs[1] = '{1'b1, 3'b000, 4'b1100, 4'b1010, 4'b1000};
        vecs[2] = '{1'b0, 3'b001, 4'b1100, 4'b0011, 4'b1111};
        vecs[3] = '{1'b1, 3'b010, 4'b1111, 4'b0101, 4'b1010};
        vecs[4] = '{1'b0, 3'b100, 4'b0011, 4'b0001, 4'b0100};
        vecs[5] = '{1'b1, 3'b100, 4'b1111, 4'b0001, 4'b0000};
        vecs[6] = '{1'b0, 3'b101, 4'b0000, 4'b0001, 4'b1111};
        vecs[7] = '{1'b1, 3'b101, 4'b1001, 4'b0011, 4'b0110};
        vecs[8] = '{1'b1, 3'b011, 4'b0000, 4'b0000, 4'b1111};
        vecs[9] = '{1'b0, 3'b000, 4'b0110, 4'b0011, 4'b0010};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b1;
        repeat (3) tick();
        check("rst_outs", {alu_op, alu_a, alu_b, resp_y, resp_id, resp_valid}, '0);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        rst_n = 1'b1;
        tick();
        check("idle_noreq", {resp_valid, req1_ready, req0_ready}, 3'b000);

        // Both requesters continuously valid: grants alternate starting at req0.
        drive(1'b0, 3'b100, 4'b0011, 4'b0001);
        drive(1'b1, 3'b010, 4'b1111, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
            tick();
            check("rr_exec_ready", {req1_ready, req0_ready}, 2'b00);
            tick();
            check("rr_resp", {resp_valid, resp_id, resp_y},
                  (i % 2) ? {1'b1, 1'b1, 4'b1010} : {1'b1, 1'b0, 4'b0100});
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        foreach (vecs[i]) run_single(vecs[i]);

        // Backpressure: response held, no grant while req0 waits.
        resp_ready = 1'b0;
        drive(1'b1, 3'b001, 4'b0101, 4'b0010);
        #1;
        check("bp_grant", {req1_ready, req0_ready}, 2'b10);
        tick();
        req1_valid = 1'b0;
        drive(1'b0, 3'b010, 4'b0110, 4'b0101);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {resp_valid, resp_id, resp_y}, {1'b1, 1'b1, 4'b0111});
            check("bp_ready", {req1_ready, req0_ready}, 2'b00);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release", resp_valid, 1'b0);
        check("bp_next_grant", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        tick();
        check("bp_next_resp", {resp_valid, resp_id, resp_y}, {1'b1, 1'b0, 4'b0011});
        tick();

        // Reset in EXEC after a req0 grant (rr_ptr would otherwise be 1).
        drive(1'b0, 3'b100, 4'b0111, 4'b0001);
        tick();
        req0_valid = 1'b0;
        drive(1'b1, 3'b001, 4'b1000, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {alu_op, alu_a, alu_b, resp_y, resp_id, resp_valid}, '0);
        check("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
        tick();
        req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stray_resp", resp_valid, 1'b0);
        end
        drive(1'b0, 3'b000, 4'b0001, 4'b0001);
        drive(1'b1, 3'b000, 4'b0010, 4'b0010);
        #1;
        check("rr_after_rst", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

`ifdef ALU_FLAGS_EN
        run_single('{1'b0, 3'b100, 4'b1111, 4'b0001, 4'b0000});
        check("flag_zero", resp_zero, 1'b1);
        check("flag_carry", resp_carry, 1'b1);
        run_single('{1'b1, 3'b001, 4'b0001, 4'b0010, 4'b0011});
        check("flag_zero_clr", {resp_zero, resp_carry}, 2'b00);
`endif

        // Exhaustive XNOR through requester 1.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                vec_t v;
                v.id = 1'b1;
                v.op = 3'b011;
                v.a  = 4'(a);
                v.b  = 4'(b);
                v.y  = ~(4'(a) ^ 4'(b));
                run_single(v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
